// File: rtl/cpu_log_parser.sv
// Character-stream parser for CPU trace lines ("^time@pc: $grf <= data#" and
// "^time@pc: *addr <= data#"); classifies each line and extracts its fields.
module cpu_log_parser #(
  parameter int TIME_MAX_DIGITS = 4,
  parameter int GRF_MAX_DIGITS  = 2,
  parameter int PC_HEX_DIGITS   = 8,
  parameter int DATA_HEX_DIGITS = 8,
  parameter int ACCEPT_UPPER    = 0,
  parameter int CHECK_SEMANTIC  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         char_valid,
  input  logic [7:0]                   char,
  output logic [1:0]                   format_type,
  output logic                         line_valid,
  output logic [4*TIME_MAX_DIGITS-1:0] time_val,
  output logic [4*PC_HEX_DIGITS-1:0]   pc_val,
  output logic [4:0]                   grf_num,
  output logic [4*PC_HEX_DIGITS-1:0]   addr_val,
  output logic [4*DATA_HEX_DIGITS-1:0] data_val,
  output logic                         frame_err
);
  localparam int TW = 4*TIME_MAX_DIGITS;
  localparam int GW = 4*GRF_MAX_DIGITS;
  localparam int PW = 4*PC_HEX_DIGITS;
  localparam int DW = 4*DATA_HEX_DIGITS;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SP1, S_GRF, S_ADDR, S_SP2, S_LT, S_SP3, S_DATA
  } state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            is_mem;
  logic [TW-1:0]   t_sh;
  logic [PW-1:0]   pc_sh, addr_sh;
  logic [GW-1:0]   grf_sh;
  logic [DW-1:0]   data_sh;

  logic            is_dec, is_hex, ok, sem_ok;
  logic [3:0]      nib;

  always_comb begin
    is_dec = (char >= "0") && (char <= "9");
    is_hex = is_dec || ((char >= "a") && (char <= "f")) ||
             ((ACCEPT_UPPER != 0) && (char >= "A") && (char <= "F"));
    nib    = is_dec ? char[3:0] : char[3:0] + 4'd9;
    // grf_sh is 0 on memory lines and addr_sh is 0 on register lines
    sem_ok = (CHECK_SEMANTIC == 0) ||
             (((grf_sh >> 5) == '0) && (pc_sh[1:0] == 2'b00) && (addr_sh[1:0] == 2'b00));
    ok = 1'b1;
    case (state)
      S_TIME: ok = (is_dec && cnt < 8'(TIME_MAX_DIGITS)) || (char == "@" && cnt != 8'd0);
      S_PC:   ok = (is_hex && cnt < 8'(PC_HEX_DIGITS)) || (char == ":" && cnt == 8'(PC_HEX_DIGITS));
      S_SP1:  ok = (char == " ") || (char == "$") || (char == "*");
      // spaces before the first register digit are tolerated ("$ 5")
      S_GRF:  ok = (is_dec && cnt < 8'(GRF_MAX_DIGITS)) || (char == " ") ||
                   (char == "<" && cnt != 8'd0);
      S_ADDR: ok = (is_hex && cnt < 8'(PC_HEX_DIGITS)) ||
                   ((char == " " || char == "<") && cnt == 8'(PC_HEX_DIGITS));
      S_SP2:  ok = (char == " ") || (char == "<");
      S_LT:   ok = (char == "=");
      S_SP3:  ok = (char == " ") || is_hex;
      S_DATA: ok = (is_hex && cnt < 8'(DATA_HEX_DIGITS)) ||
                   (char == "#" && cnt == 8'(DATA_HEX_DIGITS) && sem_ok);
      default: ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE; cnt <= '0; is_mem <= 1'b0;
      t_sh <= '0; pc_sh <= '0; addr_sh <= '0; grf_sh <= '0; data_sh <= '0;
      format_type <= '0; line_valid <= 1'b0; frame_err <= 1'b0;
      time_val <= '0; pc_val <= '0; grf_num <= '0; addr_val <= '0; data_val <= '0;
    end else begin
      line_valid  <= 1'b0;
      frame_err   <= 1'b0;
      format_type <= '0;
      if (char_valid) begin
        if (char == "^") begin
          // IDLE covers both "nothing pending" and "previous char closed a line"
          frame_err <= (state != S_IDLE);
          state <= S_TIME; cnt <= '0; is_mem <= 1'b0;
          t_sh <= '0; pc_sh <= '0; addr_sh <= '0; grf_sh <= '0; data_sh <= '0;
        end else if (!ok) begin
          state     <= S_IDLE;
          frame_err <= 1'b1;
        end else begin
          case (state)
            S_TIME: if (is_dec) begin
                      t_sh <= t_sh * TW'(10) + TW'(nib);
                      cnt  <= cnt + 8'd1;
                    end else begin
                      state <= S_PC; cnt <= '0;
                    end
            S_PC:   if (is_hex) begin
                      pc_sh <= PW'({pc_sh, nib});
                      cnt   <= cnt + 8'd1;
                    end else begin
                      state <= S_SP1; cnt <= '0;
                    end
            S_SP1:  if (char == "$") begin
                      state <= S_GRF; is_mem <= 1'b0; cnt <= '0;
                    end else if (char == "*") begin
                      state <= S_ADDR; is_mem <= 1'b1; cnt <= '0;
                    end
            S_GRF:  if (is_dec) begin
                      grf_sh <= grf_sh * GW'(10) + GW'(nib);
                      cnt    <= cnt + 8'd1;
                    end else if (char == "<") state <= S_LT;
                    else if (cnt != 8'd0) state <= S_SP2;
            S_ADDR: if (is_hex) begin
                      addr_sh <= PW'({addr_sh, nib});
                      cnt     <= cnt + 8'd1;
                    end else if (char == "<") state <= S_LT;
                    else state <= S_SP2;
            S_SP2:  if (char == "<") state <= S_LT;
            S_LT:   state <= S_SP3;
            S_SP3:  if (is_hex) begin
                      data_sh <= DW'(nib);
                      cnt     <= 8'd1;
                      state   <= S_DATA;
                    end
            S_DATA: if (is_hex) begin
                      data_sh <= DW'({data_sh, nib});
                      cnt     <= cnt + 8'd1;
                    end else begin
                      state       <= S_IDLE;
                      line_valid  <= 1'b1;
                      format_type <= {is_mem, ~is_mem};
                      time_val    <= t_sh;
                      pc_val      <= pc_sh;
                      grf_num     <= 5'(grf_sh);
                      addr_val    <= addr_sh;
                      data_val    <= data_sh;
                    end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu_log_parser.sv
// Directed bench: table of trace lines with hand-computed results, plus
// char_valid gaps and asynchronous reset mid-line; a second instance has semantic checks off.
module tb_cpu_log_parser;
  logic clk, reset, char_valid;
  logic [7:0] char;
  logic [1:0] format_type, ns_format_type;
  logic line_valid, frame_err, ns_line_valid, ns_frame_err;
  logic [15:0] time_val, ns_time_val;
  logic [31:0] pc_val, addr_val, data_val, ns_pc_val, ns_addr_val, ns_data_val;
  logic [4:0] grf_num, ns_grf_num;

  cpu_log_parser dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
    .format_type(format_type), .line_valid(line_valid), .time_val(time_val),
    .pc_val(pc_val), .grf_num(grf_num), .addr_val(addr_val), .data_val(data_val),
    .frame_err(frame_err));

  cpu_log_parser #(.CHECK_SEMANTIC(0)) dut_ns (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
    .format_type(ns_format_type), .line_valid(ns_line_valid), .time_val(ns_time_val),
    .pc_val(ns_pc_val), .grf_num(ns_grf_num), .addr_val(ns_addr_val), .data_val(ns_data_val),
    .frame_err(ns_frame_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int lv_cnt, fe_cnt, ns_lv_cnt, wbad = 0;
  logic [1:0] last_ft;
  logic prev_lv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (line_valid) begin lv_cnt++; last_ft = format_type; end
    if (frame_err) fe_cnt++;
    if (ns_line_valid) ns_lv_cnt++;
    if ((line_valid && prev_lv) || (frame_err && prev_fe)) wbad++;
    if (!line_valid && format_type != 2'b00) wbad++;
    prev_lv = line_valid;
    prev_fe = frame_err;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr();
    lv_cnt = 0; fe_cnt = 0; ns_lv_cnt = 0; last_ft = 2'b00;
  endtask

  // one char per negedge; with gap=1 an ignored '#' is presented between chars
  task automatic send_str(input string s, input bit gap, input bit drain);
    for (int i = 0; i < s.len(); i++) begin
      if (gap) begin char_valid = 1'b0; char = "#"; @(negedge clk); end
      char = s[i]; char_valid = 1'b1; @(negedge clk);
    end
    if (drain) begin
      char_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  typedef struct {
    string s;
    int lv, fe, ns_lv;
    logic [1:0] ft;
    logic [31:0] t, pc, grf, addr, data;
  } vec_t;
  vec_t v[16];

  initial begin
    reset = 1'b1; char_valid = 1'b0; char = 8'h00;
    clr();
    repeat (3) @(negedge clk);
    chk("rst.ft", 32'(format_type), 0);
    chk("rst.lv", 32'(line_valid), 0);
    chk("rst.fe", 32'(frame_err), 0);
    chk("rst.time", 32'(time_val), 0);
    chk("rst.pc", pc_val, 0);
    chk("rst.grf", 32'(grf_num), 0);
    chk("rst.addr", addr_val, 0);
    chk("rst.data", data_val, 0);
    reset = 1'b0;
    @(negedge clk);

    v[0]  = '{"^10@00003010: $ 5 <= 0000abcd#", 1, 0, 1, 2'b01, 10, 'h3010, 5, 0, 'habcd};
    v[1]  = '{"^7@00003000: *00000010<=deadbeef#", 1, 0, 1, 2'b10, 7, 'h3000, 0, 'h10, 'hdeadbeef};
    v[2]  = '{"^8@00000008: *0000000c <=12345678#^1@00000004: $31<=00000001#", 2, 0, 2, 2'b01, 1, 4, 31, 0, 1};
    v[3]  = '{"^12345@00003000: $1<=00000001#", 0, 1, 0, 2'b00, 1, 4, 31, 0, 1};
    v[4]  = '{"^5@0000300: $1<=00000001#", 0, 1, 0, 2'b00, 1, 4, 31, 0, 1};
    v[5]  = '{"^5@00003000: $32<=00000001#", 0, 1, 1, 2'b00, 1, 4, 31, 0, 1};
    v[6]  = '{"^5@00003011: $1<=00000001#", 0, 1, 1, 2'b00, 1, 4, 31, 0, 1};
    v[7]  = '{"^9@0000000C: $2<=00000002#", 0, 1, 0, 2'b00, 1, 4, 31, 0, 1};
    v[8]  = '{"^3@000^2@00000010: $2 <= 000000ff#", 1, 1, 1, 2'b01, 2, 'h10, 2, 0, 'hff};
    v[9]  = '{"^1@00000000: $123<=00000000#", 0, 1, 0, 2'b00, 2, 'h10, 2, 0, 'hff};
    v[10] = '{"^1@00000000: $1<=000000001#", 0, 1, 0, 2'b00, 2, 'h10, 2, 0, 'hff};
    v[11] = '{"^1@00000000: $1<=0000001#", 0, 1, 0, 2'b00, 2, 'h10, 2, 0, 'hff};
    v[12] = '{"^@00000000: $1<=00000001#", 0, 1, 0, 2'b00, 2, 'h10, 2, 0, 'hff};
    v[13] = '{"^9999@00000100: *000000f0 <= cafef00d#", 1, 0, 1, 2'b10, 9999, 'h100, 0, 'hf0, 'hcafef00d};
    v[14] = '{"zz#:^0@00000020: $ 7  <=  00000007#", 1, 0, 1, 2'b01, 0, 'h20, 7, 0, 7};
    v[15] = '{"^1@00000000: *00000012<=00000001#", 0, 1, 1, 2'b00, 0, 'h20, 7, 0, 7};

    for (int i = 0; i < 16; i++) begin
      clr();
      send_str(v[i].s, 1'b0, 1'b1);
      chk($sformatf("v%0d.lv", i), 32'(lv_cnt), 32'(v[i].lv));
      chk($sformatf("v%0d.fe", i), 32'(fe_cnt), 32'(v[i].fe));
      chk($sformatf("v%0d.ns_lv", i), 32'(ns_lv_cnt), 32'(v[i].ns_lv));
      chk($sformatf("v%0d.ft", i), 32'(last_ft), 32'(v[i].ft));
      chk($sformatf("v%0d.time", i), 32'(time_val), v[i].t);
      chk($sformatf("v%0d.pc", i), pc_val, v[i].pc);
      chk($sformatf("v%0d.grf", i), 32'(grf_num), v[i].grf);
      chk($sformatf("v%0d.addr", i), addr_val, v[i].addr);
      chk($sformatf("v%0d.data", i), data_val, v[i].data);
    end

    // the unchecked instance accepts what the checked one rejected
    chk("ns.addr12", ns_addr_val, 'h12);
    chk("ns.data12", ns_data_val, 1);
    clr();
    send_str("^5@00003000: $32<=00000001#", 1'b0, 1'b1);
    chk("ns.grf32", 32'(ns_grf_num), 0);
    chk("ns.pc32", ns_pc_val, 'h3000);
    chk("ns.addr32", ns_addr_val, 0);
    chk("sem.grf_hold", 32'(grf_num), 7);
    clr();
    send_str("^5@00003011: $1<=00000001#", 1'b0, 1'b1);
    chk("ns.pc3011", ns_pc_val, 'h3011);
    chk("ns.grf1", 32'(ns_grf_num), 1);
    chk("sem.pc_hold", pc_val, 'h20);

    // char_valid gaps must not disturb the parse
    clr();
    send_str("^10@00003010: $ 5 <= 0000abcd#", 1'b1, 1'b1);
    chk("gap.lv", 32'(lv_cnt), 1);
    chk("gap.fe", 32'(fe_cnt), 0);
    chk("gap.ft", 32'(last_ft), 1);
    chk("gap.time", 32'(time_val), 10);
    chk("gap.pc", pc_val, 'h3010);
    chk("gap.grf", 32'(grf_num), 5);
    chk("gap.data", data_val, 'habcd);

    // asynchronous reset between edges in the middle of the data field
    clr();
    send_str("^5@00000040: $3<=0000", 1'b0, 1'b0);
    char = "1"; char_valid = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst.data", data_val, 0);
    chk("arst.pc", pc_val, 0);
    chk("arst.time", 32'(time_val), 0);
    chk("arst.grf", 32'(grf_num), 0);
    @(negedge clk);
    reset = 1'b0;
    send_str("abcd#", 1'b0, 1'b1);
    chk("arst.tail_lv", 32'(lv_cnt), 0);
    chk("arst.tail_fe", 32'(fe_cnt), 0);
    chk("arst.tail_data", data_val, 0);
    clr();
    send_str("^6@00000044: $4<=00000004#", 1'b0, 1'b1);
    chk("post.lv", 32'(lv_cnt), 1);
    chk("post.fe", 32'(fe_cnt), 0);
    chk("post.pc", pc_val, 'h44);
    chk("post.data", data_val, 4);

    chk("pulse_width", 32'(wbad), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
